csi_rx_multi_vc_handler: RTL and testbench

Next-generation CSI-2 packet handler: parses combined 32-bit link words from the word combiner and tracks frame/line state independently for up to four virtual channels. It sits between dphy_rx_word_combiner and the pixel pipeline, in place of the single-VC handler. It also tags payload words with VC and line number, and enforces packet timeout and LP abort.

---
 rtl/csi_rx_multi_vc_handler.sv | 192 +++++++++++++++++++
 tb/tb_csi_rx_multi_vc_handler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/csi_rx_multi_vc_handler.sv
// csi_rx_multi_vc_handler: CSI-2 packet parser with per-VC frame/line tracking; optional CSI_HDR_ECC_EN adds the header ECC check and the ecc_error port
module csi_rx_multi_vc_handler #(
    parameter logic [3:0]  VC_MASK  = 4'b0001,
    parameter logic [5:0]  FS_DT    = 6'h00,
    parameter logic [5:0]  FE_DT    = 6'h01,
    parameter logic [5:0]  VIDEO_DT = 6'h2A,
    parameter logic [15:0] MAX_LEN  = 16'd8192,
    parameter int          LINE_W   = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       data,
    input  logic              data_enable,
    input  logic              data_frame,
    input  logic              lp_detect,
    output logic              sync_wait,
    output logic              packet_done,
    output logic [31:0]       payload,
    output logic              payload_enable,
    output logic              payload_frame,
    output logic [1:0]        payload_vc,
    output logic [LINE_W-1:0] payload_line,
    output logic [3:0]        vsync,
    output logic [3:0]        in_frame,
`ifdef CSI_HDR_ECC_EN
    output logic [3:0]        in_line,
    output logic              ecc_error
`else
    output logic [3:0]        in_line
`endif
);
    localparam logic S_IDLE    = 1'b0;
    localparam logic S_PAYLOAD = 1'b1;

    logic              state_q, state_d;
    logic [15:0]       rem_q, rem_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [1:0]        vc_q, vc_d;
    logic              emit_q, emit_d;
    logic              sync_wait_q, sync_wait_d;
    logic              packet_done_q, packet_done_d;
    logic [31:0]       payload_q, payload_d;
    logic              payload_enable_q, payload_enable_d;
    logic              payload_frame_q, payload_frame_d;
    logic [1:0]        payload_vc_q, payload_vc_d;
    logic [LINE_W-1:0] payload_line_q, payload_line_d;
    logic [3:0]        vsync_q, vsync_d;
    logic [3:0]        in_frame_q, in_frame_d;
    logic [3:0]        in_line_q, in_line_d;
    logic [LINE_W-1:0] line_q [4];
    logic [LINE_W-1:0] line_d [4];
    logic              ecc_ok, ecc_error_d;

    wire [1:0]  h_vc = data[7:6];
    wire [5:0]  h_dt = data[5:0];
    wire [15:0] h_wc = data[23:8];
    wire hdr   = state_q == S_IDLE && data_enable && data_frame;
    wire acc   = VC_MASK[h_vc] && ecc_ok;
    wire vid   = acc && h_dt == VIDEO_DT && in_frame_q[h_vc];
    wire word  = state_q == S_PAYLOAD && data_enable;
    wire last  = word && rem_q == 16'd1;
    wire tout  = word && !last && cnt_q == MAX_LEN - 16'd1;
    wire lp    = state_q == S_PAYLOAD && lp_detect;

`ifdef CSI_HDR_ECC_EN
    logic ecc_error_q;

    // CSI-2 6-bit Hamming parity over the 24 header bits; top two ECC bits must be zero
    function automatic logic [5:0] ecc6(input logic [23:0] d);
        return {^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
                ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
    endfunction

    assign ecc_ok    = data[31:24] == {2'b00, ecc6(data[23:0])};
    assign ecc_error = ecc_error_q;
`else
    assign ecc_ok = 1'b1;
`endif

    // Packet sequencing, per-VC frame/line bookkeeping and payload forwarding
    always_comb begin
        state_d          = state_q;
        rem_d            = rem_q;
        cnt_d            = cnt_q;
        vc_d             = vc_q;
        emit_d           = emit_q;
        in_frame_d       = in_frame_q;
        line_d           = line_q;
        payload_d        = payload_q;
        payload_vc_d     = payload_vc_q;
        payload_line_d   = payload_line_q;
        vsync_d          = 4'b0000;
        packet_done_d    = 1'b0;
        payload_enable_d = 1'b0;
        ecc_error_d      = 1'b0;
        if (hdr) begin
            vc_d        = h_vc;
            emit_d      = vid;
            rem_d       = 16'(({1'b0, h_wc} + 17'd3) >> 2);
            cnt_d       = 16'd0;
            ecc_error_d = !ecc_ok;
            payload_vc_d   = vid ? h_vc : payload_vc_q;
            payload_line_d = vid ? line_q[h_vc] : payload_line_q;
            if (acc && h_dt == FS_DT) begin
                vsync_d[h_vc]    = 1'b1;
                in_frame_d[h_vc] = 1'b1;
                line_d[h_vc]     = '0;
            end
            if (acc && h_dt == FE_DT) in_frame_d[h_vc] = 1'b0;
            if (h_dt < 6'h10 || h_wc == 16'd0) begin
                packet_done_d = 1'b1;
                if (vid) line_d[h_vc] = line_q[h_vc] + LINE_W'(1);
            end else begin
                state_d = S_PAYLOAD;
            end
        end else if (lp) begin
            state_d       = S_IDLE;
            packet_done_d = 1'b1;
        end else if (word) begin
            rem_d            = rem_q - 16'd1;
            cnt_d            = cnt_q + 16'd1;
            payload_enable_d = emit_q;
            payload_d        = emit_q ? data : payload_q;
            if (last || tout) begin
                state_d       = S_IDLE;
                packet_done_d = 1'b1;
            end
            if (last && emit_q) line_d[vc_q] = line_q[vc_q] + LINE_W'(1);
        end
        in_line_d       = (state_d == S_PAYLOAD && emit_d) ? (4'b0001 << vc_d) : 4'b0000;
        payload_frame_d = |in_line_d || payload_enable_d;
        sync_wait_d     = state_d == S_IDLE && !packet_done_d;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            rem_q            <= '0;
            cnt_q            <= '0;
            vc_q             <= '0;
            emit_q           <= 1'b0;
            sync_wait_q      <= 1'b1;
            packet_done_q    <= 1'b0;
            payload_q        <= '0;
            payload_enable_q <= 1'b0;
            payload_frame_q  <= 1'b0;
            payload_vc_q     <= '0;
            payload_line_q   <= '0;
            vsync_q          <= '0;
            in_frame_q       <= '0;
            in_line_q        <= '0;
            line_q           <= '{default: '0};
        end else begin
            state_q          <= state_d;
            rem_q            <= rem_d;
            cnt_q            <= cnt_d;
            vc_q             <= vc_d;
            emit_q           <= emit_d;
            sync_wait_q      <= sync_wait_d;
            packet_done_q    <= packet_done_d;
            payload_q        <= payload_d;
            payload_enable_q <= payload_enable_d;
            payload_frame_q  <= payload_frame_d;
            payload_vc_q     <= payload_vc_d;
            payload_line_q   <= payload_line_d;
            vsync_q          <= vsync_d;
            in_frame_q       <= in_frame_d;
            in_line_q        <= in_line_d;
            line_q           <= line_d;
        end
    end

`ifdef CSI_HDR_ECC_EN
    // One-cycle flag for a header whose ECC did not match
    always_ff @(posedge clock) begin
        if (!reset_n) ecc_error_q <= 1'b0;
        else ecc_error_q <= ecc_error_d;
    end
`endif

    assign sync_wait      = sync_wait_q;
    assign packet_done    = packet_done_q;
    assign payload        = payload_q;
    assign payload_enable = payload_enable_q;
    assign payload_frame  = payload_frame_q;
    assign payload_vc     = payload_vc_q;
    assign payload_line   = payload_line_q;
    assign vsync          = vsync_q;
    assign in_frame       = in_frame_q;
    assign in_line        = in_line_q;
endmodule

// File: tb/tb_csi_rx_multi_vc_handler.sv
// tb_csi_rx_multi_vc_handler: packet-level model of the multi-VC handler, checked every cycle, plus directed literal checks
module tb_csi_rx_multi_vc_handler;
    localparam logic [3:0]  MASK  = 4'b1011;
    localparam int          MAXL  = 6;
    localparam int          LW    = 3;
    localparam logic [5:0]  FS    = 6'h00;
    localparam logic [5:0]  FE    = 6'h01;
    localparam logic [5:0]  VID   = 6'h2A;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [31:0]   data;
    logic          data_enable, data_frame, lp_detect;
    logic          sync_wait, packet_done, payload_enable, payload_frame;
    logic [31:0]   payload;
    logic [1:0]    payload_vc;
    logic [LW-1:0] payload_line;
    logic [3:0]    vsync, in_frame, in_line;

    csi_rx_multi_vc_handler #(.VC_MASK(MASK), .MAX_LEN(16'(MAXL)), .LINE_W(LW)) dut (
        .clock(clock), .reset_n(reset_n), .data(data), .data_enable(data_enable),
        .data_frame(data_frame), .lp_detect(lp_detect), .sync_wait(sync_wait),
        .packet_done(packet_done), .payload(payload), .payload_enable(payload_enable),
        .payload_frame(payload_frame), .payload_vc(payload_vc), .payload_line(payload_line),
        .vsync(vsync), .in_frame(in_frame), .in_line(in_line)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // expected outputs for the current cycle
    logic          e_sync, e_done, e_pen, e_pframe;
    logic [31:0]   e_pay;
    logic [1:0]    e_pvc;
    logic [LW-1:0] e_pline;
    logic [3:0]    e_vsync, e_inframe, e_inline;

    // model state: which VCs are inside a frame, and each VC's next line index
    logic [3:0]    m_frame = 4'b0000;
    logic [LW-1:0] m_line [4] = '{default: '0};

    // observations used by the literal checks
    int            pay_cnt = 0;
    logic [31:0]   last_pay = '0;
    logic [LW-1:0] last_pline = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("sync_wait", 32'(sync_wait), 32'(e_sync));
            chk("packet_done", 32'(packet_done), 32'(e_done));
            chk("payload_enable", 32'(payload_enable), 32'(e_pen));
            chk("payload_frame", 32'(payload_frame), 32'(e_pframe));
            chk("vsync", 32'(vsync), 32'(e_vsync));
            chk("in_frame", 32'(in_frame), 32'(e_inframe));
            chk("in_line", 32'(in_line), 32'(e_inline));
            if (e_pen) begin
                chk("payload", payload, e_pay);
                chk("payload_vc", 32'(payload_vc), 32'(e_pvc));
                chk("payload_line", 32'(payload_line), 32'(e_pline));
            end
            if (payload_enable) begin
                pay_cnt++;
                last_pay = payload;
                last_pline = payload_line;
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_exp();
        e_sync = 1'b1; e_done = 1'b0; e_pen = 1'b0; e_pframe = 1'b0;
        e_vsync = 4'b0000; e_inline = 4'b0000; e_inframe = m_frame;
    endtask

    // Drives one packet; lp_at = word slot replaced by an LP abort (0 = none); pat = 0x11111111*i words
    task automatic send_packet(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                               input int lp_at, input bit pat);
        bit acc, emit;
        int n, i;
        logic [31:0] w;
        acc  = MASK[vc];
        emit = acc && dt == VID && m_frame[vc];
        n    = (int'(wc) + 3) / 4;
        data = {8'($urandom), wc, vc, dt};
        data_enable = 1'b1; data_frame = 1'b1; lp_detect = 1'b0;
        cyc();
        idle_exp();
        if (acc && dt == FS) begin
            m_frame[vc] = 1'b1;
            m_line[vc] = '0;
            e_vsync = 4'b0001 << vc;
        end
        if (acc && dt == FE) m_frame[vc] = 1'b0;
        e_inframe = m_frame;
        e_sync = 1'b0;
        if (dt < 6'h10 || wc == 16'd0) begin
            e_done = 1'b1;
            if (emit) m_line[vc] = m_line[vc] + 1'b1;
        end else begin
            e_inline = emit ? (4'b0001 << vc) : 4'b0000;
            e_pframe = emit;
            i = 0;
            while (1) begin
                if ($urandom_range(3) == 0) begin
                    data_enable = 1'b0; data = $urandom;
                    cyc();
                    e_vsync = 4'b0000; e_pen = 1'b0;
                    continue;
                end
                i++;
                if (i == lp_at) begin
                    lp_detect = 1'b1; data_enable = 1'($urandom_range(1)); data = $urandom;
                    cyc();
                    lp_detect = 1'b0;
                    e_vsync = 4'b0000; e_done = 1'b1; e_pen = 1'b0; e_pframe = 1'b0; e_inline = 4'b0000;
                    break;
                end
                w = pat ? i * 32'h11111111 : $urandom;
                data = w; data_enable = 1'b1;
                cyc();
                e_vsync = 4'b0000; e_pen = emit; e_pay = w; e_pvc = vc; e_pline = m_line[vc];
                if (i == n || i == MAXL) begin
                    e_done = 1'b1; e_inline = 4'b0000; e_pframe = emit;
                    if (i == n && emit) m_line[vc] = m_line[vc] + 1'b1;
                    break;
                end
            end
        end
        data_enable = 1'($urandom_range(1)); data_frame = 1'b0; data = $urandom;
        cyc();
        idle_exp();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        int base;
        logic [5:0] dt;
        logic [15:0] wc;
        int n, lp_at;
        reset_n = 1'b0; data = '0; data_enable = 1'b0; data_frame = 1'b0; lp_detect = 1'b0;
        idle_exp();
        e_pay = '0; e_pvc = '0; e_pline = '0;
        cyc();
        chk_en = 1'b1;
        repeat (3) cyc();
        @(negedge clock);
        chk("rst sync_wait", 32'(sync_wait), 32'd1);
        chk("rst payload", payload, 32'd0);
        chk("rst in_frame", 32'(in_frame), 32'd0);
        cyc();
        reset_n = 1'b1;
        cyc();

        send_packet(2'd0, FS, 16'd0, 0, 1'b0);
        chk("fs vc0 in_frame", 32'(in_frame), 32'h1);
        base = pay_cnt;
        send_packet(2'd0, VID, 16'd16, 0, 1'b1);
        chk("line0 count", 32'(pay_cnt - base), 32'd4);
        chk("line0 last word", last_pay, 32'h44444444);
        chk("line0 index", 32'(last_pline), 32'd0);
        send_packet(2'd0, VID, 16'd16, 0, 1'b1);
        chk("line1 index", 32'(last_pline), 32'd1);

        send_packet(2'd1, FS, 16'd0, 0, 1'b0);
        base = pay_cnt;
        send_packet(2'd1, VID, 16'd40, 4, 1'b0);
        chk("lp word count", 32'(pay_cnt - base), 32'd3);
        chk("lp in_line", 32'(in_line), 32'd0);
        send_packet(2'd1, VID, 16'd8, 0, 1'b0);
        chk("after lp index", 32'(last_pline), 32'd0);

        base = pay_cnt;
        send_packet(2'd0, VID, 16'd64, 0, 1'b0);
        chk("timeout count", 32'(pay_cnt - base), 32'd6);
        send_packet(2'd0, VID, 16'd4, 0, 1'b0);
        chk("after timeout index", 32'(last_pline), 32'd2);
        send_packet(2'd0, FE, 16'd0, 0, 1'b0);
        chk("fe vc0 in_frame", 32'(in_frame), 32'h2);

        send_packet(2'd2, FS, 16'd0, 0, 1'b0);
        chk("unaccepted fs", 32'(in_frame), 32'h2);
        base = pay_cnt;
        send_packet(2'd3, VID, 16'd12, 0, 1'b0);
        chk("no frame no payload", 32'(pay_cnt - base), 32'd0);

        send_packet(2'd1, VID, 16'd0, 0, 1'b0);
        send_packet(2'd1, VID, 16'd4, 0, 1'b0);
        chk("wc0 increments", 32'(last_pline), 32'd2);

        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(9))
                0: dt = FS;
                1: dt = FE;
                2: dt = 6'h05;
                3: dt = 6'h2B;
                default: dt = VID;
            endcase
            wc = ($urandom_range(7) == 0) ? 16'd0 : 16'($urandom_range(40));
            n = (int'(wc) + 3) / 4;
            lp_at = ($urandom_range(5) == 0 && n > 0) ? int'($urandom_range(n, 1)) : 0;
            send_packet(2'($urandom_range(3)), dt, wc, lp_at, 1'b0);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
